// File: rtl/status_monitor_irq.sv
// Sticky status collector for saturation channels and system sources, with
// per-bit level/edge set, saturating per-channel event counters and IRQ outputs.
module status_monitor_irq #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned CFG_W = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic                  HF_CLK,
  input  logic                  RST_sync,
  input  logic                  ENSAMP_sync,
  input  logic [CFG_W-1:0]      CRCCFG,
  input  logic [N_CH-1:0]       AFERSTCH_sync,
  input  logic                  FIFO_OVERFLOW_sync,
  input  logic                  FIFO_UNDERFLOW_sync,
  input  logic                  ADCOVERFLOW,
  input  logic [N_CH-1:0]       SATDETECT_sync,
  input  logic [N_CH+4:0]       edge_mode,
  input  logic [N_CH+5:0]       irq_mask,
  input  logic                  status_clr_pulse,
  input  logic [N_CH+5:0]       status_clr_mask,
  output logic [N_CH+5:0]       status,
  output logic [N_CH*CNT_W-1:0] sat_count,
  output logic                  irq,
  output logic                  irq_pulse
);

  localparam int unsigned SW    = N_CH + 6;
  localparam int unsigned NS    = SW - 1;
  localparam int unsigned B_ADC = N_CH;
  localparam int unsigned B_OVF = N_CH + 1;
  localparam int unsigned B_UDF = N_CH + 2;
  localparam int unsigned B_ARS = N_CH + 3;
  localparam int unsigned B_CFG = N_CH + 4;
  localparam int unsigned B_ENS = N_CH + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NS-1:0]           src_c;
  logic [NS-1:0]           src_d;
  logic [NS-1:0]           evt_c;
  logic [NS-1:0]           clr_c;
  logic [SW-1:0]           status_next_c;
  logic [N_CH-1:0]         sat_rise_c;
  logic [N_CH*CNT_W-1:0]   sat_count_next_c;
  logic                    irq_next_c;
  logic                    irq_pulse_next_c;
  logic                    cfg_armed;
  logic [CFG_W-1:0]        crccfg_prev;
  logic                    unused_clr_msb_c;

  assign unused_clr_msb_c = status_clr_mask[SW-1];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Raw source levels; the CFGCHNG slot has no level source of its own.
  always_comb begin
    src_c        = '0;
    src_c[N_CH-1:0] = SATDETECT_sync;
    src_c[B_ADC] = ADCOVERFLOW;
    src_c[B_OVF] = FIFO_OVERFLOW_sync;
    src_c[B_UDF] = FIFO_UNDERFLOW_sync;
    src_c[B_ARS] = |AFERSTCH_sync;
    src_c[B_CFG] = 1'b0;
  end

  // Edge-mode bits mask out the cycles where the source was already high.
  always_comb begin
    evt_c        = src_c & ~(edge_mode & src_d);
    evt_c[B_CFG] = cfg_armed && (CRCCFG != crccfg_prev);
  end

  assign clr_c = {NS{status_clr_pulse}} & status_clr_mask[NS-1:0];

  // Set has priority over a same-cycle W1C.
  always_comb begin
    status_next_c         = '0;
    status_next_c[NS-1:0] = evt_c | (status[NS-1:0] & ~clr_c);
    status_next_c[B_ENS]  = ENSAMP_sync;
  end

  assign sat_rise_c = SATDETECT_sync & ~src_d[N_CH-1:0];

  // A clear coinciding with a new edge leaves the count at one.
  always_comb begin
    sat_count_next_c = sat_count;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (sat_rise_c[i]) begin
        sat_count_next_c[i*CNT_W +: CNT_W] =
          clr_c[i] ? CNT_W'(1) : sat_inc(sat_count[i*CNT_W +: CNT_W]);
      end else if (clr_c[i]) begin
        sat_count_next_c[i*CNT_W +: CNT_W] = '0;
      end
    end
  end

  assign irq_next_c       = |(status_next_c & irq_mask);
  assign irq_pulse_next_c = |(status_next_c[NS-1:0] & ~status[NS-1:0] & irq_mask[NS-1:0]);

  always_ff @(posedge HF_CLK or posedge RST_sync) begin
    if (RST_sync) begin
      status      <= '0;
      sat_count   <= '0;
      irq         <= 1'b0;
      irq_pulse   <= 1'b0;
      src_d       <= '0;
      cfg_armed   <= 1'b0;
      crccfg_prev <= '0;
    end else begin
      status      <= status_next_c;
      sat_count   <= sat_count_next_c;
      irq         <= irq_next_c;
      irq_pulse   <= irq_pulse_next_c;
      src_d       <= src_c;
      cfg_armed   <= 1'b1;
      crccfg_prev <= CRCCFG;
    end
  end

endmodule

// File: tb/tb_status_monitor_irq.sv
// Randomised and directed bench for status_monitor_irq against a behavioural model.
module tb_status_monitor_irq;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned CFG_W = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SW    = N_CH + 6;
  localparam int unsigned EMW   = SW - 1;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic hf_clk = 1'b0;
  always #5 hf_clk = ~hf_clk;

  logic                  rst;
  logic                  ensamp;
  logic [CFG_W-1:0]      crccfg;
  logic [N_CH-1:0]       afer;
  logic                  fovf, fudf, adcovf;
  logic [N_CH-1:0]       satdet;
  logic [EMW-1:0]        edge_mode;
  logic [SW-1:0]         irq_mask;
  logic                  clr_pulse;
  logic [SW-1:0]         clr_mask;
  logic [SW-1:0]         status;
  logic [N_CH*CNT_W-1:0] sat_count;
  logic                  irq, irq_pulse;

  logic                  ens4, adc4;
  logic [3:0]            sat4;
  logic [9:0]            status4;
  logic [15:0]           cnt4;
  logic                  irq4, pulse4;

  int unsigned total = 0;
  int unsigned bad   = 0;

  status_monitor_irq #(.N_CH(N_CH), .CFG_W(CFG_W), .CNT_W(CNT_W)) dut (
    .HF_CLK(hf_clk), .RST_sync(rst), .ENSAMP_sync(ensamp), .CRCCFG(crccfg),
    .AFERSTCH_sync(afer), .FIFO_OVERFLOW_sync(fovf), .FIFO_UNDERFLOW_sync(fudf),
    .ADCOVERFLOW(adcovf), .SATDETECT_sync(satdet), .edge_mode(edge_mode),
    .irq_mask(irq_mask), .status_clr_pulse(clr_pulse), .status_clr_mask(clr_mask),
    .status(status), .sat_count(sat_count), .irq(irq), .irq_pulse(irq_pulse)
  );

  status_monitor_irq #(.N_CH(4), .CFG_W(16), .CNT_W(4)) dut4 (
    .HF_CLK(hf_clk), .RST_sync(rst), .ENSAMP_sync(ens4), .CRCCFG(16'h0000),
    .AFERSTCH_sync(4'h0), .FIFO_OVERFLOW_sync(1'b0), .FIFO_UNDERFLOW_sync(1'b0),
    .ADCOVERFLOW(adc4), .SATDETECT_sync(sat4), .edge_mode(9'h000),
    .irq_mask(10'h3FF), .status_clr_pulse(1'b0), .status_clr_mask(10'h000),
    .status(status4), .sat_count(cnt4), .irq(irq4), .irq_pulse(pulse4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  bit             m_flag [EMW];
  bit             m_ens;
  int             m_cnt  [N_CH];
  bit             m_prev [EMW];
  bit             m_armed;
  logic [CFG_W-1:0] m_prev_cfg;
  bit             m_irq, m_pulse;

  task automatic model_reset();
    for (int b = 0; b < int'(EMW); b++) begin
      m_flag[b] = 1'b0;
      m_prev[b] = 1'b0;
    end
    for (int i = 0; i < int'(N_CH); i++) m_cnt[i] = 0;
    m_ens = 1'b0; m_armed = 1'b0; m_prev_cfg = '0; m_irq = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_step();
    bit src [EMW];
    bit nf  [SW];
    bit ev, rise;
    int c;
    for (int i = 0; i < int'(N_CH); i++) src[i] = satdet[i];
    src[N_CH]   = adcovf;
    src[N_CH+1] = fovf;
    src[N_CH+2] = fudf;
    src[N_CH+3] = (afer != '0);
    src[N_CH+4] = 1'b0;
    for (int b = 0; b < int'(EMW); b++) begin
      if (b == int'(N_CH) + 4) ev = m_armed && (crccfg != m_prev_cfg);
      else if (edge_mode[b])   ev = src[b] && !m_prev[b];
      else                     ev = src[b];
      if (ev)                            nf[b] = 1'b1;
      else if (clr_pulse && clr_mask[b]) nf[b] = 1'b0;
      else                               nf[b] = m_flag[b];
    end
    nf[SW-1] = ensamp;
    m_irq = 1'b0; m_pulse = 1'b0;
    for (int b = 0; b < int'(SW); b++) begin
      if (nf[b] && irq_mask[b]) m_irq = 1'b1;
      if (b < int'(EMW) && nf[b] && !m_flag[b] && irq_mask[b]) m_pulse = 1'b1;
    end
    for (int i = 0; i < int'(N_CH); i++) begin
      rise = satdet[i] && !m_prev[i];
      c = (clr_pulse && clr_mask[i]) ? 0 : m_cnt[i];
      if (rise) c = (c + 1 > CMAX) ? CMAX : c + 1;
      m_cnt[i] = c;
    end
    for (int b = 0; b < int'(EMW); b++) begin
      m_flag[b] = nf[b];
      m_prev[b] = src[b];
    end
    m_ens = nf[SW-1];
    m_armed = 1'b1;
    m_prev_cfg = crccfg;
  endtask

  // Apply current inputs for one clock and compare all outputs with the model.
  task automatic cycle();
    logic [SW-1:0]         e_status;
    logic [N_CH*CNT_W-1:0] e_cnt;
    model_step();
    @(posedge hf_clk);
    #1;
    for (int b = 0; b < int'(EMW); b++) e_status[b] = m_flag[b];
    e_status[SW-1] = m_ens;
    for (int i = 0; i < int'(N_CH); i++) e_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    chk("status", 64'(status), 64'(e_status));
    chk("sat_count", 64'(sat_count), 64'(e_cnt));
    chk("irq", 64'(irq), 64'(m_irq));
    chk("irq_pulse", 64'(irq_pulse), 64'(m_pulse));
  endtask

  task automatic idle_inputs();
    satdet = '0; afer = '0; fovf = 1'b0; fudf = 1'b0; adcovf = 1'b0;
    clr_pulse = 1'b0; clr_mask = '0;
  endtask

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      if (k % 32 == 0) begin
        edge_mode = EMW'($urandom);
        irq_mask  = SW'($urandom);
      end
      for (int i = 0; i < int'(N_CH); i++) begin
        satdet[i] = ($urandom_range(0, 3) == 0);
        afer[i]   = ($urandom_range(0, 15) == 0);
      end
      fovf   = ($urandom_range(0, 7) == 0);
      fudf   = ($urandom_range(0, 7) == 0);
      adcovf = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) crccfg = CFG_W'($urandom);
      if ($urandom_range(0, 7) == 0) ensamp = ~ensamp;
      clr_pulse = ($urandom_range(0, 5) == 0);
      clr_mask  = SW'($urandom);
      cycle();
    end
  endtask

  int npulse;

  initial begin
    rst = 1'b1; ensamp = 1'b0; crccfg = 16'hA5A5; edge_mode = '0; irq_mask = '0;
    ens4 = 1'b0; adc4 = 1'b0; sat4 = '0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge hf_clk);
    #1;
    chk("rst_status", 64'(status), 64'h0);
    chk("rst_count", 64'(sat_count), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_pulse", 64'(irq_pulse), 64'h0);
    rst = 1'b0;

    // CFGCHNG suppressed after reset, flagged on a real change
    irq_mask = 14'h1000;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("cfg_quiet", 64'(status[12]), 64'h0);
    end
    crccfg = 16'hA5A4;
    cycle();
    chk("cfg_set", 64'(status[12]), 64'h1);
    chk("cfg_irq", 64'(irq), 64'h1);
    chk("cfg_pulse", 64'(irq_pulse), 64'h1);
    clr_pulse = 1'b1; clr_mask = 14'h1000;
    cycle();
    chk("cfg_clr", 64'(status[12]), 64'h0);
    idle_inputs();

    // Edge-mode SAT0 held high, cleared mid-hold
    edge_mode = 13'h0001; irq_mask = 14'h0001; npulse = 0;
    for (int k = 0; k < 20; k++) begin
      satdet[0] = 1'b1;
      clr_pulse = (k == 5);
      clr_mask  = (k == 5) ? 14'h0001 : 14'h0000;
      cycle();
      npulse += int'(irq_pulse);
      if (k == 0) chk("edge_set", 64'(status[0]), 64'h1);
      if (k == 5) chk("edge_clr", 64'(status[0]), 64'h0);
    end
    chk("edge_hold", 64'(status[0]), 64'h0);
    chk("edge_npulse", 64'(npulse), 64'h1);
    idle_inputs();
    edge_mode = '0;
    cycle();
    npulse = 0;
    for (int k = 0; k < 20; k++) begin
      satdet[0] = 1'b1;
      clr_pulse = (k == 5);
      clr_mask  = (k == 5) ? 14'h0001 : 14'h0000;
      cycle();
      npulse += int'(irq_pulse);
      if (k == 5) chk("level_clr", 64'(status[0]), 64'h1);
    end
    chk("level_npulse", 64'(npulse), 64'h1);
    idle_inputs();

    // Set beats same-cycle clear on FIFO_OVF
    for (int k = 0; k < 2; k++) begin
      fovf = 1'b1; clr_pulse = 1'b1; clr_mask = 14'h0200;
      cycle();
      chk("ovf_setwins", 64'(status[9]), 64'h1);
    end
    fovf = 1'b0;
    cycle();
    chk("ovf_clr", 64'(status[9]), 64'h0);
    idle_inputs();

    // Counter saturation and clear-with-edge
    for (int k = 0; k < 20; k++) begin
      satdet[3] = 1'b1; cycle();
      satdet[3] = 1'b0; cycle();
    end
    chk("cnt_sat", 64'(sat_count[15:12]), 64'hF);
    satdet[3] = 1'b1; clr_pulse = 1'b1; clr_mask = 14'h0008;
    cycle();
    chk("cnt_clr_edge", 64'(sat_count[15:12]), 64'h1);
    idle_inputs();

    // Masked ADC_OVF, then unmask
    irq_mask = '0; adcovf = 1'b1;
    cycle();
    chk("adc_set", 64'(status[8]), 64'h1);
    chk("adc_masked_irq", 64'(irq), 64'h0);
    adcovf = 1'b0; irq_mask = 14'h0100;
    cycle();
    chk("unmask_irq", 64'(irq), 64'h1);
    chk("unmask_pulse", 64'(irq_pulse), 64'h0);

    rand_cycles(400);
    idle_inputs();

    // Narrow build: ENSAMP at bit 9, ADC_OVF at bit 4
    ensamp = 1'b1; ens4 = 1'b1; adc4 = 1'b1;
    cycle();
    chk("n4_status_a", 64'(status4), 64'h210);
    chk("n4_irq", 64'(irq4), 64'h1);
    chk("n4_pulse", 64'(pulse4), 64'h1);
    adc4 = 1'b0; sat4 = 4'b0100;
    cycle();
    chk("n4_status_b", 64'(status4), 64'h214);
    chk("n4_cnt", 64'(cnt4), 64'h0100);

    // Asynchronous reset mid-sequence
    rst = 1'b1;
    #1;
    chk("arst_status", 64'(status), 64'h0);
    chk("arst_count", 64'(sat_count), 64'h0);
    chk("arst_irq", 64'(irq), 64'h0);
    chk("arst_pulse", 64'(irq_pulse), 64'h0);
    chk("arst_status4", 64'(status4), 64'h0);
    chk("arst_cnt4", 64'(cnt4), 64'h0);
    model_reset();
    repeat (2) @(posedge hf_clk);
    #1;
    chk("arst_hold", 64'(status), 64'h0);
    rst = 1'b0;
    ens4 = 1'b0; sat4 = '0;
    rand_cycles(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
